ex_alu_core: RTL and testbench
==============================

# ex_alu_core

Execute-stage arithmetic unit that consumes the 4-bit `alu_ctrl` code from the ALU control decoder, together with the two operands from the ID/EX register. It produces a registered result and a zero flag for the EX/MEM register. Most operations complete in one cycle. Shifts run either through a single-cycle barrel shifter or an iterative 1-bit-per-cycle shifter, so the block uses a valid/ready handshake on both sides.

## Interface
- `XLEN`, 32: datapath width; shift amount width is log2(XLEN).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous kill of any in-flight or held operation (branch redirect).
- `in_valid` input 1: operation offered.
- `in_ready` output 1: block can accept this cycle.
- `alu_ctrl` input 4: operation code.
- `op_a` input XLEN: operand A (rs1 or PC).
- `op_b` input XLEN: operand B (rs2 or immediate).
- `rd_in` input 5: destination tag, carried through unchanged.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts result.
- `result` output XLEN: operation result.
- `zero` output 1: `result == 0`.
- `rd_out` output 5: tag of the current result.

## Operation
- Codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU, 1010 PASS_B.
  - 1011–1111 execute as ADD.
- Arithmetic is modulo 2^XLEN; there is no overflow flag. SLT/SLTU return 1 or 0, zero-extended.
- Shift amount is `op_b[log2(XLEN)-1:0]`; upper bits of `op_b` are ignored. SRA replicates `op_a[XLEN-1]`.
- FSM states:
  - IDLE: no result held.
  - SHIFT: iterative shift in progress.
  - DONE: result held, `out_valid`=1.
- Accept happens when `in_valid && in_ready`:
  - Non-shift op, or shift with amount 0: go to DONE.
  - Iterative shift with amount N>0: load the shift register, set count=N, go to SHIFT.
- SHIFT: one 1-bit shift per cycle, count decrements, go to DONE when count reaches 0.
- DONE with `out_ready`=1: result consumed; next state is DONE if a new op is accepted in the same cycle (or SHIFT for an iterative shift), else IDLE.
- DONE with `out_ready`=0: `result`, `zero` and `rd_out` held stable.
- `in_ready` = !rst && !flush && (state==IDLE || (state==DONE && out_ready)). It is 0 in SHIFT.
- `flush`: next state IDLE, `out_valid` 0, shift abandoned. If `in_valid` is also high, flush wins and nothing is accepted.
- `rst` has priority over `flush`.

## Timing
- Reset values: `out_valid`=0, `result`=0, `zero`=1, `rd_out`=0, state IDLE.
- `in_ready` is 0 during reset and 1 in the first cycle after reset.
- Latency, measured from the accept edge T:
  - Non-shift ops: `out_valid` at T+1.
  - Barrel shift: T+1.
  - Iterative shift by N: T+1+N (N=0 gives T+1).
- Throughput: one op per cycle back-to-back when `out_ready` stays high and no iterative shift is in flight.
- All outputs are registered; only `in_ready` is combinational from state, `out_ready`, `flush` and `rst`.

## Configuration
- `EX_BARREL_SHIFT_EN` defined:
  - Shifts are computed combinationally and complete in one cycle.
  - SHIFT state is unreachable.
- `EX_BARREL_SHIFT_EN` undefined:
  - Iterative shifter, N+1 cycle latency for shifts.
  - Smaller area.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package `ex_pkg`:
  - ALU_* localparams for the 4-bit codes, shared with the ALU control decoder.
  - State enum {IDLE, SHIFT, DONE}.
  - `XLEN` default.
- One sub-module, `ex_shifter`:
  - Contains both the barrel and iterative implementations, selected by the macro.
  - start/done interface to the `ex_alu_core` FSM.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 -> `result`=0x80000000, `zero`=0, `out_valid` one cycle after accept.
- SUB 5-5, SLT 0xFFFFFFFF vs 1, SLTU 0xFFFFFFFF vs 1 -> results 0 (`zero`=1), 1, 0.
- SRA 0x80000000 by `op_b`=0x24 (amount 4) -> 0xF8000000.
  - Iterative build: latency 5, `in_ready`=0 for 4 cycles.
  - Barrel build: latency 1.
- Back-to-back stream of 8 ANDs with `out_ready` dropped for 3 cycles mid-stream -> no loss or duplication, outputs held stable while stalled, `rd_out` tags in order.
- `flush` during a SHIFT of amount 20 (iterative), with `in_valid` also high -> `out_valid` 0 next cycle, op not accepted, `in_ready`=1 the cycle after.
- Undefined code 1111 with A=3, B=4 -> `result`=7. PASS_B with B=0x12345000 -> `result`=0x12345000.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, FSM states and
// the default datapath width.
package ex_pkg;

  localparam int unsigned DEF_XLEN = 32;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return ctrl inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/ex_shifter.sv
// Shift unit for ex_alu_core. EX_BARREL_SHIFT_EN selects a single-cycle barrel
// shifter; otherwise a 1-bit-per-cycle iterative shifter is built.
import ex_pkg::*;

module ex_shifter #(
  parameter int unsigned XLEN = DEF_XLEN,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [1:0]      i_kind,
  input  logic [XLEN-1:0] i_a,
  input  logic [SHW-1:0]  i_amt,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

`ifdef EX_BARREL_SHIFT_EN

  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_flush};

  always_comb begin
    case (i_kind)
      2'b10:   o_result = i_a >> i_amt;
      2'b11:   o_result = $signed(i_a) >>> i_amt;
      default: o_result = i_a << i_amt;
    endcase
  end

  assign o_done = i_start;

`else

  logic [XLEN-1:0] r_val;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_kind;
  logic            r_busy;
  logic [XLEN-1:0] w_step;

  always_comb begin
    case (r_kind)
      2'b10:   w_step = {1'b0, r_val[XLEN-1:1]};
      2'b11:   w_step = {r_val[XLEN-1], r_val[XLEN-1:1]};
      default: w_step = {r_val[XLEN-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_val  <= '0;
      r_cnt  <= '0;
      r_kind <= 2'b00;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_val <= w_step;
      r_cnt <= r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) r_busy <= 1'b0;
    end else if (i_start && (i_amt != '0)) begin
      r_busy <= 1'b1;
      r_val  <= i_a;
      r_cnt  <= i_amt;
      r_kind <= i_kind;
    end
  end

  // When idle, a zero-amount shift completes immediately with A unchanged.
  assign o_result = r_busy ? w_step : i_a;
  assign o_done   = r_busy ? (r_cnt == SHW'(1)) : (i_start && (i_amt == '0));

`endif

endmodule

// File: rtl/ex_alu_core.sv
// Execute-stage ALU with valid/ready handshake on both sides and registered
// outputs. Shift implementation chosen by EX_BARREL_SHIFT_EN (see ex_shifter).
import ex_pkg::*;

module ex_alu_core #(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_alu_ctrl,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [4:0]      i_rd_in,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic [4:0]      o_rd_out
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_result, w_alu_res, w_sh_result, w_res_d;
  logic            r_zero, r_valid, w_valid_d, w_load;
  logic [4:0]      r_rd;
  logic            w_in_ready, w_accept, w_is_shift, w_sh_start, w_sh_done;

  assign w_in_ready = !i_rst && !i_flush &&
                      ((r_state == IDLE) || ((r_state == DONE) && i_out_ready));
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_is_shift = is_shift_op(i_alu_ctrl);
  assign w_sh_start = w_accept && w_is_shift;

  ex_shifter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shifter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_flush  (i_flush),
    .i_start  (w_sh_start),
    .i_kind   (i_alu_ctrl[1:0]),
    .i_a      (i_op_a),
    .i_amt    (i_op_b[SHW-1:0]),
    .o_done   (w_sh_done),
    .o_result (w_sh_result)
  );

  // Unlisted codes (1011-1111) fall through to ADD.
  always_comb begin
    w_alu_res = i_op_a + i_op_b;
    case (i_alu_ctrl)
      ALU_SUB:    w_alu_res = i_op_a - i_op_b;
      ALU_AND:    w_alu_res = i_op_a & i_op_b;
      ALU_OR:     w_alu_res = i_op_a | i_op_b;
      ALU_XOR:    w_alu_res = i_op_a ^ i_op_b;
      ALU_SLT:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      ALU_SLTU:   w_alu_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      ALU_PASS_B: w_alu_res = i_op_b;
      default:    w_alu_res = i_op_a + i_op_b;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_d = (w_is_shift && !w_sh_done) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (w_sh_done) w_state_d = DONE;
      end
      DONE: begin
        if (i_out_ready) begin
          if (w_accept) w_state_d = (w_is_shift && !w_sh_done) ? SHIFT : DONE;
          else          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
    if (i_flush) w_state_d = IDLE;
  end

  always_comb begin
    w_load  = 1'b0;
    w_res_d = w_alu_res;
    if (!i_flush) begin
      if (w_accept && !w_is_shift) begin
        w_load = 1'b1;
      end else if (w_sh_done) begin
        w_load  = 1'b1;
        w_res_d = w_sh_result;
      end
    end
    w_valid_d = (w_state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_rd     <= '0;
    end else begin
      r_valid <= w_valid_d;
      if (w_load) begin
        r_result <= w_res_d;
        r_zero   <= (w_res_d == '0);
      end
      if (w_accept) r_rd <= i_rd_in;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_rd_out    = r_rd;

endmodule

// File: tb/tb_ex_alu_core.sv
// Scoreboard bench for ex_alu_core: directed vectors push expected results,
// a monitor compares whenever a result is presented.
import ex_pkg::*;

module tb_ex_alu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        oready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ex_alu_core #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_alu_ctrl  (alu_ctrl),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_rd_in     (rd_in),
    .o_out_valid (out_valid),
    .i_out_ready (oready),
    .o_result    (result),
    .o_zero      (zero),
    .o_rd_out    (rd_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Checks the presented result every cycle it is valid, so stalled outputs
  // must match the same expected entry until consumed.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("result", result, sb[0].res);
        chk("zero", {31'd0, zero}, {31'd0, (sb[0].res == 32'd0)});
        chk("rd_out", {27'd0, rd_out}, {27'd0, sb[0].rd});
        if (oready) void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    int   n;
    exp_t e;
    @(negedge clk);
    alu_ctrl = c; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.res = exp;
      e.rd  = rd;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Call directly after issue(): counts cycles until out_valid and cycles with in_ready low.
  task automatic measure(input string name, input int exp_lat, input int exp_busy);
    int lat, busy;
    lat = 0; busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) busy++;
    end while (!out_valid && lat < 100);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_in_ready_low"}, busy, exp_busy);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] and_a [8];
    logic [31:0] and_b [8];
    logic [31:0] and_e [8];
    and_a = '{32'hFFFF0000, 32'h0F0F0F0F, 32'hAAAAAAAA, 32'hF0F0F0F0,
              32'h12345678, 32'hDEADBEEF, 32'h80000001, 32'hCAFEBABE};
    and_b = '{32'h12345678, 32'hFFFFFFFF, 32'h55555555, 32'h3C3C3C3C,
              32'h0000FFFF, 32'hFF00FF00, 32'hFFFFFFFF, 32'h0F0F0F0F};
    and_e = '{32'h12340000, 32'h0F0F0F0F, 32'h00000000, 32'h30303030,
              32'h00005678, 32'hDE00BE00, 32'h80000001, 32'h0A0E0A0E};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    issue(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd1, 32'h80000000);
    measure("add", 1, 0);
    issue(ALU_SUB, 32'd5, 32'd5, 5'd2, 32'd0);
    issue(ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd3, 32'd1);
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 5'd4, 32'd0);
    drain();

    issue(ALU_SRA, 32'h80000000, 32'h00000024, 5'd5, 32'hF8000000);
`ifdef EX_BARREL_SHIFT_EN
    measure("sra4", 1, 0);
`else
    measure("sra4", 5, 4);
`endif
    issue(ALU_SLL, 32'h00001234, 32'h00000020, 5'd6, 32'h00001234);
    measure("sll0", 1, 0);
    issue(ALU_SLL, 32'h00000001, 32'h0000001F, 5'd7, 32'h80000000);
    issue(ALU_SRL, 32'h80000000, 32'h0000003F, 5'd8, 32'h00000001);
    issue(ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 5'd9, 32'h0F0FF0F0);
    issue(ALU_OR, 32'h00FF0000, 32'h000000FF, 5'd10, 32'h00FF00FF);
    issue(4'b1111, 32'd3, 32'd4, 5'd11, 32'd7);
    issue(ALU_PASS_B, 32'hDEADBEEF, 32'h12345000, 5'd12, 32'h12345000);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) issue(ALU_AND, and_a[i], and_b[i], 5'(16 + i), and_e[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 oready = 1'b0;
        repeat (3) @(posedge clk);
        #1 oready = 1'b1;
      end
    join
    drain();

`ifndef EX_BARREL_SHIFT_EN
    issue(ALU_SRL, 32'hFFFFFFFF, 32'd20, 5'd21, 32'h00000FFF);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd22;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    chk("flush_abandoned", {31'd0, out_valid}, 32'd0);
`endif

    issue(ALU_ADD, 32'h00000010, 32'h00000020, 5'd31, 32'h00000030);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
